// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed multi-digit seven-segment scanner with double-buffered frames and guard time.
// Define SSD_LZ_BLANK_EN to enable leading-zero suppression.
module ssd_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dash_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    load_ack,
  output logic [6:0]              segments,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_done
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GC   = PW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [PW-1:0]           r_pre;
  logic [IW-1:0]           r_idx;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_pend_dig, r_act_dig;
  logic [NUM_DIGITS-1:0]   r_pend_dash, r_pend_blank, r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_act_dash, r_act_blank, r_act_dp;
  logic [6:0]              r_seg;
  logic                    r_dp_n, r_ack, r_fd;
  logic [NUM_DIGITS-1:0]   r_en_n;

  logic                    w_pre_tc, w_wrap, w_xfer, w_sel_blank;
  logic [PW-1:0]           w_pre_nx;
  logic [IW-1:0]           w_idx_nx;
  logic [4*NUM_DIGITS-1:0] w_dig;
  logic [NUM_DIGITS-1:0]   w_dash, w_blank_src, w_dp, w_blank;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg_nx;
  logic                    w_dp_n_nx;
  logic [NUM_DIGITS-1:0]   w_en_n_nx;

  assign w_pre_tc = r_pre == PMAX;
  assign w_wrap   = w_pre_tc && r_idx == IMAX;
  assign w_xfer   = w_wrap && r_pend_valid;
  assign w_pre_nx = w_pre_tc ? '0 : r_pre + 1'b1;
  assign w_idx_nx = w_pre_tc ? (r_idx == IMAX ? '0 : r_idx + 1'b1) : r_idx;

  // Outputs are decoded from the next-cycle state so the new frame's data lands with frame_done.
  assign w_dig       = w_xfer ? r_pend_dig   : r_act_dig;
  assign w_dash      = w_xfer ? r_pend_dash  : r_act_dash;
  assign w_blank_src = w_xfer ? r_pend_blank : r_act_blank;
  assign w_dp        = w_xfer ? r_pend_dp    : r_act_dp;

`ifdef SSD_LZ_BLANK_EN
  logic w_lead;
  always_comb begin
    w_blank = w_blank_src;
    w_lead  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_lead     = w_lead && w_dig[4*i +: 4] == 4'h0 && !w_dash[i] && !w_dp[i];
      w_blank[i] = w_blank[i] | w_lead;
    end
  end
`else
  assign w_blank = w_blank_src;
`endif

  assign w_nib       = w_dig[{w_idx_nx, 2'b00} +: 4];
  assign w_sel_blank = w_blank[w_idx_nx];
  assign w_seg_nx    = w_sel_blank ? 7'h7F : w_dash[w_idx_nx] ? 7'h3F : ~HEX[w_nib];
  assign w_dp_n_nx   = w_sel_blank | ~w_dp[w_idx_nx];
  assign w_en_n_nx   = (w_pre_nx < GC) ? '1 : ~(NUM_DIGITS'(1) << w_idx_nx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre        <= '0;
      r_idx        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_dig   <= '0;
      r_pend_dash  <= '0;
      r_pend_blank <= '1;
      r_pend_dp    <= '0;
      r_act_dig    <= '0;
      r_act_dash   <= '0;
      r_act_blank  <= '1;
      r_act_dp     <= '0;
      r_seg        <= 7'h7F;
      r_dp_n       <= 1'b1;
      r_en_n       <= '1;
      r_ack        <= 1'b0;
      r_fd         <= 1'b0;
    end else begin
      r_pre        <= w_pre_nx;
      r_idx        <= w_idx_nx;
      r_pend_valid <= load | (r_pend_valid & ~w_wrap);
      if (load) begin
        r_pend_dig   <= digits_in;
        r_pend_dash  <= dash_in;
        r_pend_blank <= blank_in;
        r_pend_dp    <= dp_in;
      end
      r_act_dig    <= w_dig;
      r_act_dash   <= w_dash;
      r_act_blank  <= w_blank_src;
      r_act_dp     <= w_dp;
      r_seg        <= w_seg_nx;
      r_dp_n       <= w_dp_n_nx;
      r_en_n       <= w_en_n_nx;
      r_ack        <= w_xfer;
      r_fd         <= w_wrap;
    end
  end

  assign segments   = r_seg;
  assign dp_n       = r_dp_n;
  assign digit_en_n = r_en_n;
  assign load_ack   = r_ack;
  assign frame_done = r_fd;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: scoreboard bench for ssd_scan_driver (4 digits, 4-cycle slots, 1 guard cycle).
// Honours SSD_LZ_BLANK_EN when the design is built with it.
module tb_ssd_scan_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dash_in = '0, blank_in = '0, dp_in = '0;
  logic        load_ack, dp_n, frame_done;
  logic [6:0]  segments;
  logic [3:0]  digit_en_n;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [27:0] seg;
    logic [3:0]  dpn;
    logic        ack;
  } exp_t;
  exp_t q[$];

  ssd_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dash_in(dash_in),
    .blank_in(blank_in), .dp_in(dp_in), .load_ack(load_ack), .segments(segments),
    .dp_n(dp_n), .digit_en_n(digit_en_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [15:0] dig, input logic [3:0] dash, input logic [3:0] blank,
                          input logic [3:0] dp, input logic ack);
    exp_t e;
    logic [3:0] bl, nib;
    logic lead;
    bl = blank;
    lead = 1'b1;
`ifdef SSD_LZ_BLANK_EN
    for (int i = 3; i > 0; i--) begin
      nib = dig[4*i +: 4];
      lead = lead && nib == 4'h0 && !dash[i] && !dp[i];
      if (lead) bl[i] = 1'b1;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      nib = dig[4*i +: 4];
      e.seg[7*i +: 7] = bl[i] ? 7'h7F : dash[i] ? 7'h3F : ~HEX[nib];
      e.dpn[i] = bl[i] | ~dp[i];
    end
    e.ack = ack;
    q.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] dig, input logic [3:0] dash, input logic [3:0] blank,
                         input logic [3:0] dp);
    digits_in = dig; dash_in = dash; blank_in = blank; dp_in = dp;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Waits for the next frame boundary and checks all 16 cycles of that frame against the queue head.
  task automatic check_frame(input string name);
    exp_t e;
    logic [13:0] got, want;
    logic [3:0] one;
    int slot, n;
    bit seen;
    one = 4'b0001;
    if (q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = q.pop_front();
    seen = 0;
    for (n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      load = 1'b0;
      seen = frame_done;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL %s: frame_done timeout got 0 want 1", name);
      return;
    end
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      slot = c / 4;
      got  = {frame_done, load_ack, digit_en_n, dp_n, segments};
      want = {c == 0, c == 0 && e.ack, (c % 4 == 0) ? 4'hF : ~(one << slot), e.dpn[slot], e.seg[7*slot +: 7]};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s cyc%0d: fd/ack/en/dpn/seg got %b/%b/%h/%b/%h want %b/%b/%h/%b/%h", name, c,
                 got[13], got[12], got[11:8], got[7], got[6:0], want[13], want[12], want[11:8], want[7], want[6:0]);
      end
    end
  endtask

  task automatic test_reset;
    logic [13:0] got;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    got = {frame_done, load_ack, digit_en_n, dp_n, segments};
    n_vec++;
    if (got !== {1'b0, 1'b0, 4'hF, 1'b1, 7'h7F}) begin
      n_err++;
      $display("FAIL reset_values: got %h want %h", got, {1'b0, 1'b0, 4'hF, 1'b1, 7'h7F});
    end
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 40);
    n_vec++;
    if (n !== 16) begin
      n_err++;
      $display("FAIL first_frame_done: got cycle %0d want 16", n);
    end
    push_exp(16'h0, 4'h0, 4'hF, 4'h0, 1'b0);
    push_exp(16'h0, 4'h0, 4'hF, 4'h0, 1'b0);
    check_frame("idle1");
    check_frame("idle2");
  endtask

  task automatic test_hex;
    repeat (3) @(negedge clk);
    do_load(16'h12AF, 4'h0, 4'h0, 4'h0);
    push_exp(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b1);
    push_exp(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0);
    check_frame("hex_ack");
    check_frame("hex_hold");
  endtask

  task automatic test_dash_blank_dp;
    repeat (5) @(negedge clk);
    do_load(16'h3456, 4'b0010, 4'b0001, 4'b0010);
    push_exp(16'h3456, 4'b0010, 4'b0001, 4'b0010, 1'b1);
    check_frame("dash_blank_dp");
  endtask

  task automatic test_back_to_back;
    repeat (2) @(negedge clk);
    do_load(16'h1111, 4'h0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    do_load(16'h2222, 4'h0, 4'h0, 4'h0);
    push_exp(16'h2222, 4'h0, 4'h0, 4'h0, 1'b1);
    push_exp(16'h2222, 4'h0, 4'h0, 4'h0, 1'b0);
    check_frame("double_load");
    check_frame("double_hold");
    // Load issued on the boundary cycle itself is deferred by a frame.
    push_exp(16'h2222, 4'h0, 4'h0, 4'h0, 1'b0);
    push_exp(16'hBEEF, 4'h0, 4'h0, 4'b1000, 1'b1);
    digits_in = 16'hBEEF; dash_in = 4'h0; blank_in = 4'h0; dp_in = 4'b1000;
    load = 1'b1;
    check_frame("boundary_old");
    check_frame("boundary_new");
  endtask

  task automatic test_reset_pending;
    logic [13:0] got;
    repeat (2) @(negedge clk);
    do_load(16'h5555, 4'h0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = {frame_done, load_ack, digit_en_n, dp_n, segments};
    n_vec++;
    if (got !== {1'b0, 1'b0, 4'hF, 1'b1, 7'h7F}) begin
      n_err++;
      $display("FAIL midreset_values: got %h want %h", got, {1'b0, 1'b0, 4'hF, 1'b1, 7'h7F});
    end
    push_exp(16'h0, 4'h0, 4'hF, 4'h0, 1'b0);
    push_exp(16'h0, 4'h0, 4'hF, 4'h0, 1'b0);
    check_frame("midreset_f1");
    check_frame("midreset_f2");
  endtask

  task automatic test_leading_zero;
    repeat (3) @(negedge clk);
    do_load(16'h0070, 4'h0, 4'h0, 4'h0);
    push_exp(16'h0070, 4'h0, 4'h0, 4'h0, 1'b1);
    check_frame("lz_0070");
    repeat (3) @(negedge clk);
    do_load(16'h0000, 4'h0, 4'h0, 4'h0);
    push_exp(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1);
    check_frame("lz_0000");
    repeat (3) @(negedge clk);
    do_load(16'h0005, 4'h0, 4'h0, 4'b0100);
    push_exp(16'h0005, 4'h0, 4'h0, 4'b0100, 1'b1);
    check_frame("lz_dp_stop");
  endtask

  initial begin
    test_reset;
    test_hex;
    test_dash_blank_dp;
    test_back_to_back;
    test_reset_pending;
    test_leading_zero;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
